branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised branch prediction unit for the 5-stage RV32 pipeline; replaces "always predict not-taken, flush on every taken branch/jump".
- Contents: direct-mapped BTB with per-entry saturating direction counters, a circular return-address stack (RAS), mispredict detection and performance counters.
- IF stage looks it up combinationally. EX stage updates it with the resolved outcome and takes its redirect/flush decision from it.

Parameters:
- ENTRIES, 16: BTB entries; power of 2, ≥2; IDX_W = log2(ENTRIES).
- ADDR_W, 32: PC width.
- CTR_W, 2: direction counter width; ≥1.
- RAS_DEPTH, 4: return-stack entries; power of 2.
- PERF_W, 32: performance counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  ADDR_W  IF-stage PC
- pred_taken  out  1  IF prediction: redirect fetch
- pred_target  out  ADDR_W  IF predicted target
- upd_valid  in  1  EX holds a resolved control-flow instruction (not flushed, not stalled)
- upd_pc  in  ADDR_W  PC of that instruction
- upd_type  in  2  00 cond branch, 01 JAL, 10 JALR return (rs1=x1/x5, rd=x0), 11 other JALR
- upd_is_call  in  1  JAL/JALR with rd=x1/x5
- upd_taken  in  1  resolved direction (ignored unless type 00)
- upd_target  in  ADDR_W  resolved target
- upd_pred_taken  in  1  prediction carried down the pipeline
- upd_pred_target  in  ADDR_W  predicted target carried down the pipeline
- ex_mispredict  out  1  flush IF/ID and ID/EX, redirect PC
- ex_redirect_pc  out  ADDR_W  correct next PC
- perf_ctl  out  PERF_W  resolved control-flow count
- perf_miss  out  PERF_W  mispredict count

Behaviour:
- Index and tag:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - entry fields: valid, tag, type, target, ctr.
- Lookup (combinational, same cycle):
  - hit = valid & tag match.
  - Type 00: pred_taken = hit & ctr MSB.
  - Types 01/11: pred_taken = hit.
  - Type 10: pred_taken = hit & (ras_cnt≠0).
  - pred_target = RAS top for type 10, else the stored target.
  - pred_target = 0 when pred_taken = 0.
- Actual direction: act_taken = upd_taken for type 00, else 1.
- Mispredict (combinational):
  - ex_mispredict = upd_valid & (act_taken≠upd_pred_taken | (act_taken & upd_target≠upd_pred_target)).
  - ex_redirect_pc = act_taken ? upd_target : upd_pc+4 (mod 2^ADDR_W).
  - Both outputs are 0 when upd_valid=0.
- BTB update, registered at posedge when upd_valid:
  - Hit: type 00 counter saturates-increments if taken, saturates-decrements if not; target and type overwritten.
  - Miss, act_taken=1: allocate (replace) the entry. Counter = weakly taken (MSB=1, rest 0) for type 00, don't-care otherwise.
  - Miss, not taken: no allocation.
- Lookup/update collision: same index in the same cycle, lookup sees pre-update contents (read-before-write).
- RAS, updated at EX (non-speculative) when upd_valid:
  - Call pushes upd_pc+4. When full, the oldest entry is overwritten (pointer wraps) and the count stays RAS_DEPTH.
  - Type 10 pops. Pop when empty does nothing.
  - Call that is also type 10: pop then push, i.e. the top is replaced and the count is unchanged.
- Perf counters: on upd_valid, perf_ctl +1; on ex_mispredict, perf_miss +1. Both saturate at all-ones, no wrap.
- Reset (async, any time, including mid-update):
  - All valid bits 0, all counters to weakly not-taken (01..1 pattern with MSB=0).
  - RAS pointer and count 0, perf counters 0.
  - Outputs come out of reset as pred_taken=0, pred_target=0, ex_mispredict=0, ex_redirect_pc=0.
  - Target arrays need not be reset.
- Pipeline integration rule: IF/ID and ID/EX carry pred_taken/pred_target. The existing flush becomes ex_mispredict.

Decomposition:
- Shared package/define file: upd_type encodings, counter init values, tag/index width macros.
- One natural sub-module: bpu_ras (circular stack with push/pop/count, parameter RAS_DEPTH). The BTB arrays stay in the top block.

Test Plan:
- Reset, then if_pc=0x0000_0040 -> pred_taken=0, pred_target=0. Update with type 00 at 0x40, taken, target 0x80, pred_taken=0 -> ex_mispredict=1, redirect 0x80. Next cycle lookup 0x40 -> taken, target 0x80.
- Same branch resolved not-taken twice, then taken once -> counter 10→01→00→01. Predictions at each lookup: taken, not, not. perf_miss increments on each mispredict only.
- Not-taken cond branch at 0x100 on a miss -> no allocation; lookup 0x100 stays not-taken, ex_redirect_pc=0x104 when pred_taken=0 matched (no mispredict).
- Five calls from 0x200,0x300,0x400,0x500,0x600 with RAS_DEPTH=4, then ret entry hit -> targets 0x604,0x504,0x404,0x304, then RAS empty -> pred_taken=0 for the return.
- Aliasing PCs 0x40 and 0x40+4*ENTRIES -> tag mismatch gives no hit; a same-cycle update to the same index shows old data on lookup, new data the next cycle.
- Assert rst_n low mid-update with perf_ctl=0xFFFF_FFFF saturated -> all outputs 0 immediately; after release, lookups miss.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
// ============================================================================
// branch_predict_unit_pkg : shared encodings and width helpers for the BPU
// Revision: 1.0
// ============================================================================
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    UPD_BR   = 2'b00,
    UPD_JAL  = 2'b01,
    UPD_RET  = 2'b10,
    UPD_JALR = 2'b11
  } upd_type_e;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_width(input int addr_w, input int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

  // Weakly taken: MSB set, rest clear. Weakly not-taken is one below it.
  function automatic logic [31:0] ctr_weak_taken(input int ctr_w);
    return 32'(1) << (ctr_w - 1);
  endfunction

  function automatic logic [31:0] ctr_weak_not_taken(input int ctr_w);
    return (32'(1) << (ctr_w - 1)) - 32'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// branch_predict_unit_if : IF lookup / EX resolve bundle between pipeline and BPU
// Revision: 1.0
// ============================================================================
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [1:0]        upd_type;
  logic              upd_is_call;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              ex_mispredict;
  logic [ADDR_W-1:0] ex_redirect_pc;
  logic [PERF_W-1:0] perf_ctl;
  logic [PERF_W-1:0] perf_miss;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_type, upd_is_call, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, ex_mispredict, ex_redirect_pc,
           perf_ctl, perf_miss
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_type, upd_is_call, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, ex_mispredict, ex_redirect_pc,
           perf_ctl, perf_miss
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit_ras.sv
`default_nettype none
// ============================================================================
// bpu_ras : circular return-address stack; overflow overwrites the oldest entry
// Revision: 1.0
// ============================================================================
module bpu_ras #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic              empty;
  logic              full;
  logic              replace;

  // ptr_q names the next free slot; the top lives one below it.
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign replace = push_i & pop_i & ~empty;
  assign top_o   = mem_q[ptr_dec];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (replace) begin
      ptr_q <= ptr_q;
    end else if (push_i) begin
      ptr_q <= ptr_inc;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i && !empty) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[replace ? ptr_dec : ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// branch_predict_unit : direct-mapped BTB + counters, RAS, mispredict detect, perf
// Revision: 1.0
// ============================================================================
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int ADDR_W    = 32,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4,
  parameter int PERF_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = tag_width(ADDR_W, ENTRIES);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  upd_type_e         type_q  [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];

  logic [PERF_W-1:0] perf_ctl_q;
  logic [PERF_W-1:0] perf_miss_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  upd_type_e         up_type;
  logic              upd_en;
  logic              act_taken;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [CTR_W-1:0]  ctr_d;

  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_cnt;

  // ---------------- IF lookup ----------------
  assign lk_idx = bus.if_pc[IDX_W+1:2];
  assign lk_tag = bus.if_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    case (type_q[lk_idx])
      UPD_BR:  pred_taken = lk_hit & ctr_q[lk_idx][CTR_W-1];
      UPD_RET: pred_taken = lk_hit & (ras_cnt != '0);
      default: pred_taken = lk_hit;
    endcase
    if (pred_taken) begin
      pred_target = (type_q[lk_idx] == UPD_RET) ? ras_top : tgt_q[lk_idx];
    end
  end

  // ---------------- EX resolve ----------------
  // Gating with rst_n keeps the EX outputs quiet while reset is held.
  assign upd_en    = bus.upd_valid & rst_n;
  assign up_type   = upd_type_e'(bus.upd_type);
  assign up_idx    = bus.upd_pc[IDX_W+1:2];
  assign up_tag    = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign act_taken = (up_type == UPD_BR) ? bus.upd_taken : 1'b1;
  assign pc_plus4  = bus.upd_pc + ADDR_W'(4);

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (upd_en) begin
      mispredict  = (act_taken != bus.upd_pred_taken) |
                    (act_taken & (bus.upd_target != bus.upd_pred_target));
      redirect_pc = act_taken ? bus.upd_target : pc_plus4;
    end
  end

  always_comb begin
    ctr_d = ctr_q[up_idx];
    if (bus.upd_taken) begin
      if (ctr_q[up_idx] != '1) ctr_d = ctr_q[up_idx] + 1'b1;
    end else begin
      if (ctr_q[up_idx] != '0) ctr_d = ctr_q[up_idx] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (up_type == UPD_BR) ctr_q[up_idx] <= ctr_d;
      end else if (act_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

  // Tag/type/target carry no reset; an entry is meaningless until valid.
  always_ff @(posedge clk) begin
    if (upd_en && (up_hit || act_taken)) begin
      tag_q[up_idx]  <= up_tag;
      type_q[up_idx] <= up_type;
      tgt_q[up_idx]  <= bus.upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ctl_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (upd_en && (perf_ctl_q != '1))      perf_ctl_q  <= perf_ctl_q + 1'b1;
      if (mispredict && (perf_miss_q != '1)) perf_miss_q <= perf_miss_q + 1'b1;
    end
  end

  bpu_ras #(
    .DEPTH  (RAS_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ras (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (upd_en & bus.upd_is_call),
    .pop_i  (upd_en & (up_type == UPD_RET)),
    .data_i (pc_plus4),
    .top_o  (ras_top),
    .cnt_o  (ras_cnt)
  );

  assign bus.pred_taken     = pred_taken;
  assign bus.pred_target    = pred_target;
  assign bus.ex_mispredict  = mispredict;
  assign bus.ex_redirect_pc = redirect_pc;
  assign bus.perf_ctl       = perf_ctl_q;
  assign bus.perf_miss      = perf_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_predict_unit : directed checks of lookup, update, RAS, perf, reset
// Revision: 1.0
// ============================================================================
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.ADDR_W(32), .PERF_W(32)) bus ();
  branch_predict_unit_if #(.ADDR_W(32), .PERF_W(3))  bus2 ();

  branch_predict_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_predict_unit #(.PERF_W(3)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_type = 2'b00;
    bus.upd_is_call = 1'b0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    bus.upd_pred_taken = 1'b0; bus.upd_pred_target = '0;
  endtask

  task automatic upd(input logic [31:0] pc, input upd_type_e ty, input logic call,
                     input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_type = ty;
    bus.upd_is_call = call; bus.upd_taken = tk; bus.upd_target = tgt;
    bus.upd_pred_taken = ptk; bus.upd_pred_target = ptgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_tk, input logic [31:0] exp_tgt);
    bus.if_pc = pc;
    #1;
    chk({tag, "_taken"}, 32'(bus.pred_taken), 32'(exp_tk));
    chk({tag, "_target"}, bus.pred_target, exp_tgt);
  endtask

  task automatic ex_chk(input string tag, input logic exp_m, input logic [31:0] exp_pc);
    #1;
    chk({tag, "_misp"}, 32'(bus.ex_mispredict), 32'(exp_m));
    chk({tag, "_redir"}, bus.ex_redirect_pc, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ret_exp [4];
    ret_exp[0] = 32'h604; ret_exp[1] = 32'h504;
    ret_exp[2] = 32'h404; ret_exp[3] = 32'h304;
    idle();
    bus.if_pc = 32'h0;
    bus2.if_pc = '0; bus2.upd_valid = 1'b0; bus2.upd_pc = '0; bus2.upd_type = 2'b00;
    bus2.upd_is_call = 1'b0; bus2.upd_taken = 1'b0; bus2.upd_target = '0;
    bus2.upd_pred_taken = 1'b0; bus2.upd_pred_target = '0;

    // Reset state
    #3;
    chk("rst_perf_ctl", bus.perf_ctl, 32'h0);
    chk("rst_perf_miss", bus.perf_miss, 32'h0);
    tick();
    rst_n = 1'b1;
    look("rst_look40", 32'h40, 1'b0, 32'h0);
    ex_chk("rst_ex", 1'b0, 32'h0);

    // First taken branch allocates; prediction next cycle
    upd(32'h40, UPD_BR, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    ex_chk("br_first", 1'b1, 32'h80);
    tick(); idle();
    look("br_alloc", 32'h40, 1'b1, 32'h80);
    chk("br_perf_ctl", bus.perf_ctl, 32'd1);
    chk("br_perf_miss", bus.perf_miss, 32'd1);

    // Counter walk 10 -> 01 -> 00 -> 01
    upd(32'h40, UPD_BR, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    ex_chk("nt1", 1'b1, 32'h44);
    tick(); idle();
    look("ctr01", 32'h40, 1'b0, 32'h0);
    upd(32'h40, UPD_BR, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    ex_chk("nt2", 1'b0, 32'h44);
    tick(); idle();
    look("ctr00", 32'h40, 1'b0, 32'h0);
    upd(32'h40, UPD_BR, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    ex_chk("tk3", 1'b1, 32'h80);
    tick(); idle();
    look("ctr01b", 32'h40, 1'b0, 32'h0);
    chk("walk_perf_ctl", bus.perf_ctl, 32'd4);
    chk("walk_perf_miss", bus.perf_miss, 32'd3);

    // Not-taken miss does not allocate
    upd(32'h100, UPD_BR, 1'b0, 1'b0, 32'h180, 1'b0, 32'h0);
    ex_chk("nt_miss", 1'b0, 32'h104);
    tick(); idle();
    look("no_alloc", 32'h100, 1'b0, 32'h0);
    ex_chk("idle_ex", 1'b0, 32'h0);

    // Return entry installed while RAS empty: no prediction
    upd(32'h7C, UPD_RET, 1'b0, 1'b1, 32'h999, 1'b0, 32'h0);
    ex_chk("ret_install", 1'b1, 32'h999);
    tick(); idle();
    look("ret_empty", 32'h7C, 1'b0, 32'h0);

    // Five calls into a four-deep stack
    for (int k = 2; k <= 6; k++) begin
      upd(32'(k) << 8, UPD_JAL, 1'b1, 1'b1, 32'h1000, 1'b1, 32'h1000);
      ex_chk("call", 1'b0, 32'h1000);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      bus.if_pc = 32'h7C;
      upd(32'h7C, UPD_RET, 1'b0, 1'b1, ret_exp[k], 1'b1, ret_exp[k]);
      #1;
      chk("ret_pred_taken", 32'(bus.pred_taken), 32'd1);
      chk("ret_pred_target", bus.pred_target, ret_exp[k]);
      chk("ret_misp", 32'(bus.ex_mispredict), 32'd0);
      tick();
    end
    idle();
    look("ret_drained", 32'h7C, 1'b0, 32'h0);
    chk("ras_perf_ctl", bus.perf_ctl, 32'd15);
    chk("ras_perf_miss", bus.perf_miss, 32'd4);

    // Aliasing and read-before-write
    upd(32'h40, UPD_JAL, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0);
    tick(); idle();
    look("alias_own", 32'h40, 1'b1, 32'h2000);
    look("alias_other", 32'h80, 1'b0, 32'h0);
    bus.if_pc = 32'h40;
    upd(32'h80, UPD_JAL, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h3000);
    look("rbw_old", 32'h40, 1'b1, 32'h2000);
    tick(); idle();
    look("rbw_new_old", 32'h40, 1'b0, 32'h0);
    look("rbw_new", 32'h80, 1'b1, 32'h3000);

    // Perf saturation on the narrow instance
    bus2.upd_valid = 1'b1; bus2.upd_pc = 32'h10; bus2.upd_type = UPD_JAL;
    bus2.upd_taken = 1'b1; bus2.upd_target = 32'h20;
    bus2.upd_pred_taken = 1'b1; bus2.upd_pred_target = 32'h20;
    repeat (9) tick();
    chk("sat_ctl", 32'(bus2.perf_ctl), 32'd7);
    chk("sat_miss0", 32'(bus2.perf_miss), 32'd0);
    bus2.upd_pred_taken = 1'b0; bus2.upd_pred_target = 32'h0;
    repeat (9) tick();
    chk("sat_miss", 32'(bus2.perf_miss), 32'd7);
    chk("sat_ctl_hold", 32'(bus2.perf_ctl), 32'd7);

    // Async reset mid-update
    bus.if_pc = 32'h80;
    upd(32'h40, UPD_JAL, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0);
    ex_chk("pre_rst", 1'b1, 32'h2000);
    chk("pre_rst_pred", 32'(bus.pred_taken), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_pred_taken", 32'(bus.pred_taken), 32'd0);
    chk("mrst_pred_target", bus.pred_target, 32'h0);
    chk("mrst_misp", 32'(bus.ex_mispredict), 32'd0);
    chk("mrst_redir", bus.ex_redirect_pc, 32'h0);
    chk("mrst_perf_ctl", bus.perf_ctl, 32'h0);
    chk("mrst_small_ctl", 32'(bus2.perf_ctl), 32'd0);
    chk("mrst_small_miss", 32'(bus2.perf_miss), 32'd0);
    chk("mrst_small_misp", 32'(bus2.ex_mispredict), 32'd0);
    tick();
    idle();
    bus2.upd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    look("post_rst_80", 32'h80, 1'b0, 32'h0);
    look("post_rst_40", 32'h40, 1'b0, 32'h0);
    look("post_rst_7c", 32'h7C, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
